// File: rtl/fwrisc_dbus_arbiter_if.sv
// fwrisc data bus interface shared by the masters and the slave of the arbiter.
//   daddr/dvalid/dwrite/damo/dwdata/dwstb : request fields, owned by the requester
//   lock                                  : requester keeps its grant after completion
//   drdata/dready/derr                    : response, owned by the responder
// The 'master' modport is the requester's view; 'slave' is the responder's view.
interface fwrisc_dbus_arbiter_if;
    logic [31:0] daddr;
    logic        dvalid;
    logic        dwrite;
    logic [3:0]  damo;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        lock;
    logic [31:0] drdata;
    logic        dready;
    logic        derr;

    modport master (
        output daddr, dvalid, dwrite, damo, dwdata, dwstb, lock,
        input  drdata, dready, derr
    );

    modport slave (
        input  daddr, dvalid, dwrite, damo, dwdata, dwstb, lock,
        output drdata, dready, derr
    );
endinterface

// File: rtl/fwrisc_dbus_arbiter.sv
// Two-master, one-slave arbiter for the fwrisc data bus.
//   clock, reset : clock and asynchronous active-high reset
//   m0, m1       : master-side buses (m0 = execute unit, m1 = debug/DMA requester)
//   s            : shared slave bus; s.lock mirrors the granted master's lock, s.derr is unused
//   grant_id     : currently or last granted master
//   busy         : arbiter is not idle
// Supports round-robin or fixed priority, locked sequences for atomic read-modify-write,
// and an optional timeout that completes a stalled transfer with an error.
module fwrisc_dbus_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    fwrisc_dbus_arbiter_if.slave  m0,
    fwrisc_dbus_arbiter_if.slave  m1,
    fwrisc_dbus_arbiter_if.master s,
    output logic                  grant_id,
    output logic                  busy
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrant  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    // Counter value during the last allowed GRANT cycle: expiry fires in GRANT cycle
    // number TIMEOUT_CYCLES, the cycle in which the count would reach TIMEOUT_CYCLES.
    localparam int unsigned TimeoutLastInt = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TimeoutLastInt);

    logic [1:0]           state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 rr_last_q, rr_last_d;
    logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;

    logic        in_grant;
    logic        expire;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        winner;

    // Request fields of the granted master.
    logic [31:0] sel_daddr;
    logic        sel_dvalid;
    logic        sel_dwrite;
    logic [3:0]  sel_damo;
    logic [31:0] sel_dwdata;
    logic [3:0]  sel_dwstb;
    logic        sel_lock;

    logic unused_s_derr;
    assign unused_s_derr = s.derr;

    assign grant_id = grant_q;
    assign busy     = (state_q != StIdle);

    always_comb begin
        sel_daddr  = grant_q ? m1.daddr  : m0.daddr;
        sel_dvalid = grant_q ? m1.dvalid : m0.dvalid;
        sel_dwrite = grant_q ? m1.dwrite : m0.dwrite;
        sel_damo   = grant_q ? m1.damo   : m0.damo;
        sel_dwdata = grant_q ? m1.dwdata : m0.dwdata;
        sel_dwstb  = grant_q ? m1.dwstb  : m0.dwstb;
        sel_lock   = grant_q ? m1.lock   : m0.lock;
    end

    // Outputs depend only on registered state and muxed inputs; s.dvalid never sees s.dready.
    always_comb begin
        in_grant = (state_q == StGrant);
        expire   = (TIMEOUT_CYCLES != 0) && in_grant && (tcnt_q == TimeoutLast);

        s.dvalid = in_grant && !expire;
        s.daddr  = in_grant ? sel_daddr  : 32'h0;
        s.dwrite = in_grant ? sel_dwrite : 1'b0;
        s.damo   = in_grant ? sel_damo   : 4'h0;
        s.dwdata = in_grant ? sel_dwdata : 32'h0;
        s.dwstb  = in_grant ? sel_dwstb  : 4'h0;
        s.lock   = in_grant ? sel_lock   : 1'b0;

        // A slave response on the expiry cycle wins over the timeout.
        done  = in_grant && (s.dready || expire);
        err   = expire && !s.dready;
        rdata = (in_grant && !err) ? s.drdata : 32'h0;

        m0.dready = done && !grant_q;
        m0.derr   = err && !grant_q;
        m0.drdata = grant_q ? 32'h0 : rdata;
        m1.dready = done && grant_q;
        m1.derr   = err && grant_q;
        m1.drdata = grant_q ? rdata : 32'h0;
    end

    always_comb begin
        if (m0.dvalid && m1.dvalid) begin
            winner = ROUND_ROBIN ? !rr_last_q : 1'b0;
        end else begin
            winner = m1.dvalid;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        tcnt_d    = tcnt_q;

        case (state_q)
            StIdle: begin
                if (m0.dvalid || m1.dvalid) begin
                    grant_d = winner;
                    tcnt_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (s.dready) begin
                    rr_last_d = grant_q;
                    state_d   = sel_lock ? StLocked : StIdle;
                end else if (expire) begin
                    state_d = StIdle;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StLocked: begin
                // The other master is ignored until the owner drops lock.
                if (sel_dvalid) begin
                    tcnt_d  = '0;
                    state_d = StGrant;
                end else if (!sel_lock) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= 1'b0;
            rr_last_q <= 1'b1;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            tcnt_q    <= tcnt_d;
        end
    end

endmodule
